// File: rtl/extract_ctrl_mc.sv
// extract_ctrl_mc: leaf-side packet extractor. Decodes BFT packets by port and
// type into config, instruction-memory writes, start control, or one of
// NUM_IN_PORTS buffered stream channels. Outbound traffic passes straight through.
module extract_ctrl_mc #(
    parameter int PACKET_BITS     = 97,
    parameter int PAYLOAD_BITS    = 64,
    parameter int NUM_LEAF_BITS   = 6,
    parameter int NUM_PORT_BITS   = 4,
    parameter int NUM_IN_PORTS    = 7,
    parameter int FIFO_DEPTH      = 4,
    parameter int INSTR_ADDR_BITS = 10,
    parameter int PULSE_CYCLES    = 1
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [PACKET_BITS-1:0]              din_leaf_bft2interface,
    output logic [PACKET_BITS-1:0]              dout_leaf_interface2bft,
    input  logic                                resend,
    output logic                                resend_out,
    input  logic [PACKET_BITS-1:0]              stream_in,
    output logic [NUM_IN_PORTS*PACKET_BITS-1:0] stream_out,
    output logic [NUM_IN_PORTS-1:0]             stream_valid,
    input  logic [NUM_IN_PORTS-1:0]             stream_ready,
    output logic [PACKET_BITS-1:0]              configure_out,
    output logic                                configure_valid,
    output logic                                instr_wr_en,
    output logic [INSTR_ADDR_BITS-1:0]          instr_addr,
    output logic [31:0]                         instr_packet,
    output logic                                ap_start_user,
    output logic                                ap_start_pulse_user,
    output logic [NUM_IN_PORTS-1:0]             overflow,
    output logic [15:0]                         drop_count
);

    localparam int PORT_MSB = PACKET_BITS - 2 - NUM_LEAF_BITS;
    localparam int PTR_BITS = $clog2(FIFO_DEPTH);
    localparam int CNT_BITS = $clog2(PULSE_CYCLES + 1);
    localparam logic [PTR_BITS:0]          FULL_CNT      = (PTR_BITS + 1)'(FIFO_DEPTH);
    localparam logic [NUM_PORT_BITS-1:0]   FIRST_CH_PORT = NUM_PORT_BITS'(2);
    localparam logic [NUM_PORT_BITS-1:0]   LAST_CH_PORT  = NUM_PORT_BITS'(NUM_IN_PORTS + 1);
    localparam logic [CNT_BITS-1:0]        PULSE_LOAD    = CNT_BITS'(PULSE_CYCLES);

    typedef enum logic [2:0] {
        DEC_NONE,
        DEC_CONFIG,
        DEC_INSTR,
        DEC_SET,
        DEC_CLEAR,
        DEC_STREAM,
        DEC_DISCARD
    } dec_e;

    logic                     pkt_vld;
    logic [NUM_PORT_BITS-1:0] pkt_port;
    logic [1:0]               pkt_type;
    dec_e                     dec;

    // Per-channel FIFO state
    logic [PACKET_BITS-1:0] mem_q    [NUM_IN_PORTS][FIFO_DEPTH];
    logic [PTR_BITS-1:0]    wr_ptr_q [NUM_IN_PORTS];
    logic [PTR_BITS-1:0]    rd_ptr_q [NUM_IN_PORTS];
    logic [PTR_BITS:0]      count_q  [NUM_IN_PORTS];
    logic [NUM_IN_PORTS-1:0] push, pop, full, wr_en, ovf_drop;

    // Control registers and their next states
    logic [PACKET_BITS-1:0]     cfg_q, cfg_d;
    logic                       cfg_vld_q, cfg_vld_d;
    logic                       instr_en_q, instr_en_d;
    logic [31:0]                instr_pkt_q, instr_pkt_d;
    logic [INSTR_ADDR_BITS-1:0] instr_addr_q, instr_addr_d;
    logic [INSTR_ADDR_BITS-1:0] ptr_q, ptr_d;
    logic                       start_q, start_d;
    logic [CNT_BITS-1:0]        pulse_cnt_q, pulse_cnt_d;
    logic                       pulse_q, pulse_d;
    logic [NUM_IN_PORTS-1:0]    overflow_q, overflow_d;
    logic [15:0]                drop_q, drop_d;
    logic                       drop_event;

    assign pkt_vld  = din_leaf_bft2interface[PACKET_BITS-1];
    assign pkt_port = din_leaf_bft2interface[PORT_MSB -: NUM_PORT_BITS];
    assign pkt_type = din_leaf_bft2interface[PAYLOAD_BITS+1:PAYLOAD_BITS];

    assign dout_leaf_interface2bft = stream_in;
    assign resend_out              = resend;

    // Classify the incoming packet by port and type field
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        dec = DEC_NONE;
        if (pkt_vld) begin
            if (pkt_port == '0) begin
                case (pkt_type)
                    2'd0:    dec = DEC_CONFIG;
                    2'd1:    dec = DEC_INSTR;
                    2'd2:    dec = DEC_SET;
                    default: dec = DEC_CLEAR;
                endcase
            end else if (pkt_port >= FIRST_CH_PORT && pkt_port <= LAST_CH_PORT) begin
                dec = DEC_STREAM;
            end else if (pkt_type == 2'd0) begin
                dec = DEC_CONFIG;
            end else begin
                dec = DEC_DISCARD;
            end
        end
    end

    // Channel FIFO handshake: push/pop/drop decisions and head presentation
    always_comb begin
        push         = '0;
        pop          = '0;
        full         = '0;
        wr_en        = '0;
        ovf_drop     = '0;
        stream_valid = '0;
        stream_out   = '0;
        for (int k = 0; k < NUM_IN_PORTS; k++) begin
            push[k]         = (dec == DEC_STREAM) && (pkt_port == NUM_PORT_BITS'(k + 2));
            stream_valid[k] = (count_q[k] != '0);
            full[k]         = (count_q[k] == FULL_CNT);
            pop[k]          = stream_valid[k] & stream_ready[k];
            wr_en[k]        = push[k] & (~full[k] | pop[k]);
            ovf_drop[k]     = push[k] & full[k] & ~pop[k];
            if (stream_valid[k]) begin
                stream_out[k*PACKET_BITS +: PACKET_BITS] = mem_q[k][rd_ptr_q[k]];
            end
        end
    end

    // Channel FIFO pointers and occupancy
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!reset) begin
            for (int k = 0; k < NUM_IN_PORTS; k++) begin
                wr_ptr_q[k] <= '0;
                rd_ptr_q[k] <= '0;
                count_q[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_IN_PORTS; k++) begin
                if (wr_en[k]) wr_ptr_q[k] <= wr_ptr_q[k] + PTR_BITS'(1);
                if (pop[k])   rd_ptr_q[k] <= rd_ptr_q[k] + PTR_BITS'(1);
                if (wr_en[k] && !pop[k]) begin
                    count_q[k] <= count_q[k] + (PTR_BITS + 1)'(1);
                end else if (!wr_en[k] && pop[k]) begin
                    count_q[k] <= count_q[k] - (PTR_BITS + 1)'(1);
                end
            end
        end
    end

    // Channel FIFO storage
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; pointers and occupancy alone define emptiness.
        for (int k = 0; k < NUM_IN_PORTS; k++) begin
            if (wr_en[k]) mem_q[k][wr_ptr_q[k]] <= din_leaf_bft2interface;
        end
    end

    // Next state for config, instruction, start and accounting registers
    always_comb begin
        cfg_d        = '0;
        cfg_vld_d    = 1'b0;
        instr_en_d   = 1'b0;
        instr_pkt_d  = '0;
        instr_addr_d = instr_addr_q;
        ptr_d        = ptr_q;
        start_d      = start_q;
        pulse_cnt_d  = (pulse_cnt_q != '0) ? pulse_cnt_q - CNT_BITS'(1) : '0;
        case (dec)
            DEC_CONFIG: begin
                cfg_d     = din_leaf_bft2interface;
                cfg_vld_d = 1'b1;
            end
            DEC_INSTR: begin
                instr_en_d   = 1'b1;
                instr_pkt_d  = din_leaf_bft2interface[31:0];
                instr_addr_d = ptr_q;
                ptr_d        = ptr_q + INSTR_ADDR_BITS'(1);
            end
            DEC_SET: begin
                start_d     = 1'b1;
                pulse_cnt_d = PULSE_LOAD;
            end
            DEC_CLEAR: begin
                start_d     = 1'b0;
                ptr_d       = '0;
                pulse_cnt_d = '0;
            end
            default: ;
        endcase
        pulse_d    = (pulse_cnt_d != '0);
        overflow_d = overflow_q | ovf_drop;
        drop_event = (dec == DEC_DISCARD) || (|ovf_drop);
        drop_d     = (drop_event && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;
    end

    // Control and accounting registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cfg_q        <= '0;
            cfg_vld_q    <= 1'b0;
            instr_en_q   <= 1'b0;
            instr_pkt_q  <= '0;
            instr_addr_q <= '0;
            ptr_q        <= '0;
            start_q      <= 1'b0;
            pulse_cnt_q  <= '0;
            pulse_q      <= 1'b0;
            overflow_q   <= '0;
            drop_q       <= '0;
        end else begin
            cfg_q        <= cfg_d;
            cfg_vld_q    <= cfg_vld_d;
            instr_en_q   <= instr_en_d;
            instr_pkt_q  <= instr_pkt_d;
            instr_addr_q <= instr_addr_d;
            ptr_q        <= ptr_d;
            start_q      <= start_d;
            pulse_cnt_q  <= pulse_cnt_d;
            pulse_q      <= pulse_d;
            overflow_q   <= overflow_d;
            drop_q       <= drop_d;
        end
    end

    assign configure_out       = cfg_q;
    assign configure_valid     = cfg_vld_q;
    assign instr_wr_en         = instr_en_q;
    assign instr_packet        = instr_pkt_q;
    assign instr_addr          = instr_addr_q;
    assign ap_start_user       = start_q;
    assign ap_start_pulse_user = pulse_q;
    assign overflow            = overflow_q;
    assign drop_count          = drop_q;

endmodule
